bit_packer: RTL and testbench
=============================

# bit_packer

Bitstream packer directly downstream of the ProRes header/slice field generators. Consumes the OR-merged set-bit bus (`enable`/`val`/`size_of_bit`/`flush`) and packs the variable-length fields MSB-first into 64-bit big-endian words for the frame buffer writer. It also maintains the running byte count that feeds back to the header sequencer as `set_bit_total_byte_size`.

## Interface
- `ADDR_BASE`, default 0: byte address of the first output word.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `clear`  in  1: synchronous soft clear. Same effect as reset; takes priority over all other inputs.
- `enable`  in  1: append field this cycle.
- `val`  in  64: field value, right-justified; only the low `size_of_bit` bits are used.
- `size_of_bit`  in  64: field length in bits. 0 means no-op; any value >64 is clamped to 64 and sets `err_size`.
- `flush`  in  1: zero-pad to the next byte boundary, applied after any same-cycle append.
- `drain`  in  1: append, pad, then emit every remaining byte as a final partial word.
- `out_valid`  out  1: output word valid (one cycle).
- `out_data`  out  64: packed bytes; first bit at bit 63; unused trailing bytes are 0.
- `out_byte_count`  out  4: valid bytes, 1..8 (8 for full words).
- `out_addr`  out  32: byte address of `out_data[63:56]`.
- `busy`  out  1: high during the DRAIN2 cycle; inputs are ignored while it is high.
- `total_byte_size`  out  32: committed bits >> 3, registered.
- `err_size`  out  1: sticky oversize flag; cleared only by reset or `clear`.

## Operation
- State:
  - `acc` (128b): MSB-aligned pending bits.
  - `fill` (7b): number of pending bits, 0..127.
  - `bits_total` (32b): wraps mod 2^32.
  - `addr` (32b).
  - FSM: RUN, DRAIN2.
- Append: mask `val` to n bits; place it at `acc` bit positions [127-fill .. 128-fill-n]; `fill += n`; `bits_total += n`.
- Flush: `p = (8 - fill%8)%8` zero bits; `fill += p`; `bits_total += p`.
- Emit, evaluated after append/flush in RUN:
  - If `fill` ≥ 64: output `acc[127:64]` with count 8; shift `acc` left by 64; `fill -= 64`; `addr += 8`.
  - Otherwise no output, unless `drain` is set.
- Drain in RUN:
  - `fill` < 64 after pad: emit `ceil(fill/8)` bytes, unless `fill` = 0 (then no output). Then `fill = 0`, `addr += count`.
  - `fill` ≥ 64 after pad: emit the full word now and go to DRAIN2.
  - DRAIN2: emit the remainder as a partial word (skipped if 0 bytes), then return to RUN.
- Invariant after every RUN cycle without drain: `fill` ≤ 63.
- Simultaneous `enable`+`flush`+`drain` is legal; evaluation order is append, pad, emit.
- Reset/clear (also mid-drain): all outputs 0; `acc`, `fill`, `bits_total` = 0; `addr = ADDR_BASE`; FSM → RUN. Pending bits are discarded.

## Timing
- Registered outputs; 1-cycle latency from the input cycle to `out_valid`.
- Full throughput: one field of up to 64 bits per cycle, no backpressure.
- At most one output word per cycle. `drain` may produce 2 words on consecutive cycles.
- `total_byte_size` reflects all inputs up to cycle N-1 at cycle N.
- Upstream must not assert inputs while `busy` is high; any such input is dropped.

## Structure
- Package `prores_bitpack_pkg`:
  - `ACC_W` = 128, `WORD_W` = 64, `FILL_W` = 7.
  - `typedef enum logic {RUN, DRAIN2} bp_state_t`.
  - Function `pad_bits(fill)`.
- Sub-module `bit_packer_shifter`: combinational mask/align of `val` into a 128-bit lane at offset `fill`.
- Top level holds the FSM, counters, and output registers.

## Test plan
- Eight appends of 8 bits each (0x01..0x08) → one word `0x0102030405060708`, count 8, addr 0; `total_byte_size` = 8.
- 3 bits 0b101 with `flush`, then `drain` → `out_data` 0xA000000000000000, count 1; `total_byte_size` = 1.
- 60-bit all-ones then 8-bit 0x00 → word 0xFFFFFFFFFFFFFFF0, `fill` = 4; then `drain` → 0x0000000000000000, count 1, addr 8.
- 63 bits, then 64 bits with `drain` in the same cycle → full word, `busy` for 1 cycle, then a partial word with count 8; an input driven during `busy` is ignored.
- `size_of_bit` = 100 → treated as 64, `err_size` = 1 and sticky; `clear` → all outputs 0, `addr` = `ADDR_BASE`.
- Reset asserted in DRAIN2 → no second word; FSM in RUN; `fill` = 0.

Source files
------------

// File: rtl/bit_packer_pkg.sv
// prores_bitpack_pkg: shared widths, FSM encoding and pad helper for bit_packer.
// Revision 1.0
`default_nettype none

package prores_bitpack_pkg;

  localparam int ACC_W  = 128;
  localparam int WORD_W = 64;
  localparam int FILL_W = 7;

  typedef enum logic {RUN = 1'b0, DRAIN2 = 1'b1} bp_state_t;

  // Zero bits needed to reach the next byte boundary: (8 - fill%8) % 8.
  function automatic logic [2:0] pad_bits(input logic [FILL_W:0] fill);
    return 3'((~fill + 8'd1) & 8'd7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_packer_if.sv
// bit_packer_if: set-bit input bus and packed-word output bus of bit_packer.
// Revision 1.0
`default_nettype none

interface bit_packer_if;

  logic        enable;
  logic [63:0] val;
  logic [63:0] size_of_bit;
  logic        flush;
  logic        drain;
  logic        out_valid;
  logic [63:0] out_data;
  logic [3:0]  out_byte_count;
  logic [31:0] out_addr;
  logic        busy;
  logic [31:0] total_byte_size;
  logic        err_size;

  modport master (
    output enable, val, size_of_bit, flush, drain,
    input  out_valid, out_data, out_byte_count, out_addr, busy, total_byte_size, err_size
  );

  modport slave (
    input  enable, val, size_of_bit, flush, drain,
    output out_valid, out_data, out_byte_count, out_addr, busy, total_byte_size, err_size
  );

endinterface

`default_nettype wire

// File: rtl/bit_packer_shifter.sv
// bit_packer_shifter: masks val to nbits and aligns it MSB-first below fill pending bits.
// Revision 1.0
`default_nettype none

module bit_packer_shifter
  import prores_bitpack_pkg::*;
(
  input  logic [WORD_W-1:0] val,
  input  logic [FILL_W-1:0] nbits,
  input  logic [FILL_W-1:0] fill,
  output logic [ACC_W-1:0]  lane
);

  logic [WORD_W-1:0] w_mask;
  logic [WORD_W-1:0] w_masked;
  logic [FILL_W-1:0] w_lsh;

  always_comb begin
    w_mask   = (nbits >= 7'd64) ? '1 : ((64'd1 << nbits) - 64'd1);
    w_masked = val & w_mask;
    // Lift the field's MSB to bit 127, then slide it down past the pending bits.
    w_lsh    = 7'd64 - nbits;
    lane     = ({w_masked, {WORD_W{1'b0}}} << w_lsh) >> fill;
  end

endmodule

`default_nettype wire

// File: rtl/bit_packer.sv
// bit_packer: packs variable-length fields MSB-first into 64-bit big-endian words.
// Revision 1.0
`default_nettype none

module bit_packer
  import prores_bitpack_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  bit_packer_if.slave bus
);

  bp_state_t         r_state, w_state;
  logic [ACC_W-1:0]  r_acc, w_acc;
  logic [FILL_W-1:0] r_fill, w_fill;
  logic [31:0]       r_bits, w_bits;
  logic [31:0]       r_addr, w_addr;
  logic              r_valid, w_valid;
  logic [63:0]       r_data, w_data;
  logic [3:0]        r_cnt, w_cnt;
  logic [31:0]       r_oaddr, w_oaddr;
  logic [31:0]       r_total, w_total;
  logic              r_err, w_err;

  logic              w_oversize;
  logic [FILL_W-1:0] w_nbits;
  logic [ACC_W-1:0]  w_lane, w_acc2;
  logic [FILL_W:0]   w_fill1, w_fill2, w_add;
  logic [2:0]        w_pad;

  always_comb begin
    w_oversize = bus.enable && (bus.size_of_bit > 64'd64);
    if (!bus.enable)     w_nbits = '0;
    else if (w_oversize) w_nbits = 7'd64;
    else                 w_nbits = bus.size_of_bit[6:0];
  end

  bit_packer_shifter u_shifter (
    .val   (bus.val),
    .nbits (w_nbits),
    .fill  (r_fill),
    .lane  (w_lane)
  );

  always_comb begin
    w_acc2  = r_acc | w_lane;
    w_fill1 = {1'b0, r_fill} + {1'b0, w_nbits};
    w_pad   = (bus.flush || bus.drain) ? pad_bits(w_fill1) : 3'd0;
    w_fill2 = w_fill1 + {5'd0, w_pad};
    w_add   = w_fill2 - {1'b0, r_fill};
  end

  always_comb begin
    w_state = r_state;
    w_acc   = r_acc;
    w_fill  = r_fill;
    w_bits  = r_bits;
    w_addr  = r_addr;
    w_valid = 1'b0;
    w_data  = '0;
    w_cnt   = '0;
    w_oaddr = '0;
    w_total = r_total;
    w_err   = r_err;
    case (r_state)
      RUN: begin
        w_err   = r_err | w_oversize;
        w_bits  = r_bits + {24'd0, w_add};
        w_total = {3'd0, w_bits[31:3]};
        if (w_fill2 >= 8'd64) begin
          w_valid = 1'b1;
          w_data  = w_acc2[127:64];
          w_cnt   = 4'd8;
          w_oaddr = r_addr;
          w_addr  = r_addr + 32'd8;
          w_acc   = {w_acc2[63:0], 64'd0};
          w_fill  = 7'(w_fill2 - 8'd64);
          if (bus.drain) w_state = DRAIN2;
        end else if (bus.drain) begin
          // Padded already, so the byte count is exact.
          if (w_fill2 != 8'd0) begin
            w_valid = 1'b1;
            w_data  = w_acc2[127:64];
            w_cnt   = w_fill2[6:3];
            w_oaddr = r_addr;
            w_addr  = r_addr + {28'd0, w_fill2[6:3]};
          end
          w_acc  = '0;
          w_fill = '0;
        end else begin
          w_acc  = w_acc2;
          w_fill = w_fill2[6:0];
        end
      end
      DRAIN2: begin
        if (r_fill != 7'd0) begin
          w_valid = 1'b1;
          w_data  = r_acc[127:64];
          w_cnt   = r_fill[6:3];
          w_oaddr = r_addr;
          w_addr  = r_addr + {28'd0, r_fill[6:3]};
        end
        w_acc   = '0;
        w_fill  = '0;
        w_state = RUN;
      end
      default: w_state = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_state <= RUN;
      r_acc   <= '0;
      r_fill  <= '0;
      r_bits  <= '0;
      r_addr  <= ADDR_BASE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_oaddr <= '0;
      r_total <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_acc   <= w_acc;
      r_fill  <= w_fill;
      r_bits  <= w_bits;
      r_addr  <= w_addr;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_cnt   <= w_cnt;
      r_oaddr <= w_oaddr;
      r_total <= w_total;
      r_err   <= w_err;
    end
  end

  assign bus.out_valid       = r_valid;
  assign bus.out_data        = r_data;
  assign bus.out_byte_count  = r_cnt;
  assign bus.out_addr        = r_oaddr;
  assign bus.busy            = (r_state == DRAIN2);
  assign bus.total_byte_size = r_total;
  assign bus.err_size        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bit_packer.sv
// tb_bit_packer: directed self-checking bench for bit_packer.
// Revision 1.0
`default_nettype none

module tb_bit_packer;

  localparam logic [31:0] BASE = 32'h0000_0040;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] V2   = 64'h0123_4567_89AB_CDEF;

  logic clock = 1'b0;
  logic reset_n;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  bit_packer_if bus ();

  bit_packer #(.ADDR_BASE(BASE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [63:0] sz, input logic [63:0] v,
                       input logic fl, input logic dr);
    bus.enable      = en;
    bus.val         = v;
    bus.size_of_bit = sz;
    bus.flush       = fl;
    bus.drain       = dr;
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [63:0] data, input logic [3:0] cnt,
                          input logic [31:0] addr);
    chk({tag, ".valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, ".data"},  bus.out_data, data);
    chk({tag, ".count"}, {60'd0, bus.out_byte_count}, {60'd0, cnt});
    chk({tag, ".addr"},  {32'd0, bus.out_addr}, {32'd0, addr});
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    idle();
    tick();
    tick();
    chk("rst.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst.busy",  {63'd0, bus.busy}, 64'd0);
    chk("rst.total", {32'd0, bus.total_byte_size}, 64'd0);
    chk("rst.err",   {63'd0, bus.err_size}, 64'd0);
    chk("rst.addr",  {32'd0, bus.out_addr}, 64'd0);
    reset_n = 1'b1;

    // Eight byte fields make one full word.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'd8, 64'(i), 1'b0, 1'b0);
      tick();
      if (i == 7) chk("w8.pre_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    chk_word("w8", 64'h0102_0304_0506_0708, 4'd8, BASE);
    chk("w8.total", {32'd0, bus.total_byte_size}, 64'd8);
    idle();
    tick();
    chk("w8.after_valid", {63'd0, bus.out_valid}, 64'd0);

    // 3 bits with flush, then drain: one byte.
    do_clear();
    drive(1'b1, 64'd3, 64'b101, 1'b1, 1'b0);
    tick();
    chk("fl.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("fl.total", {32'd0, bus.total_byte_size}, 64'd1);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    tick();
    chk_word("fl.drain", 64'hA000_0000_0000_0000, 4'd1, BASE);

    // 60 ones + 8 zeros spill one word, leaving 4 pending zero bits.
    do_clear();
    drive(1'b1, 64'd60, ONES, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'd8, 64'd0, 1'b0, 1'b0);
    tick();
    chk_word("s60", 64'hFFFF_FFFF_FFFF_FFF0, 4'd8, BASE);
    idle();
    tick();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    tick();
    chk_word("s60.drain", 64'd0, 4'd1, BASE + 32'd8);
    chk("s60.total", {32'd0, bus.total_byte_size}, 64'd9);

    // 63 + 64 bits with drain: full word, busy cycle, second full word.
    do_clear();
    drive(1'b1, 64'd63, ONES, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'd64, V2, 1'b0, 1'b1);
    tick();
    chk_word("d2.w1", 64'hFFFF_FFFF_FFFF_FFFE, 4'd8, BASE);
    chk("d2.busy", {63'd0, bus.busy}, 64'd1);
    chk("d2.total", {32'd0, bus.total_byte_size}, 64'd16);
    drive(1'b1, 64'd8, 64'hFF, 1'b1, 1'b0);
    tick();
    chk_word("d2.w2", 64'h0246_8ACF_1357_9BDE, 4'd8, BASE + 32'd8);
    chk("d2.busy_off", {63'd0, bus.busy}, 64'd0);
    chk("d2.total2", {32'd0, bus.total_byte_size}, 64'd16);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    tick();
    chk("d2.dropped", {63'd0, bus.out_valid}, 64'd0);
    chk("d2.total3", {32'd0, bus.total_byte_size}, 64'd16);

    // Oversize field clamps to 64 and latches the error flag.
    do_clear();
    drive(1'b1, 64'd100, ONES, 1'b0, 1'b0);
    tick();
    chk("ov.err", {63'd0, bus.err_size}, 64'd1);
    chk_word("ov", ONES, 4'd8, BASE);
    idle();
    tick();
    chk("ov.sticky", {63'd0, bus.err_size}, 64'd1);
    chk("ov.total", {32'd0, bus.total_byte_size}, 64'd8);
    do_clear();
    chk("clr.err",   {63'd0, bus.err_size}, 64'd0);
    chk("clr.total", {32'd0, bus.total_byte_size}, 64'd0);
    chk("clr.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("clr.data",  bus.out_data, 64'd0);
    drive(1'b1, 64'd8, 64'hAB, 1'b0, 1'b1);
    tick();
    chk_word("clr.drain", 64'hAB00_0000_0000_0000, 4'd1, BASE);

    // Reset during DRAIN2 discards the second word.
    do_clear();
    drive(1'b1, 64'd63, ONES, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'd64, V2, 1'b0, 1'b1);
    tick();
    chk("rd.busy", {63'd0, bus.busy}, 64'd1);
    idle();
    reset_n = 1'b0;
    tick();
    chk("rd.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rd.busy_off", {63'd0, bus.busy}, 64'd0);
    reset_n = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    tick();
    chk("rd.empty", {63'd0, bus.out_valid}, 64'd0);
    drive(1'b1, 64'd8, 64'h5A, 1'b0, 1'b1);
    tick();
    chk_word("rd.next", 64'h5A00_0000_0000_0000, 4'd1, BASE);

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
